// File: rtl/trdb_pkg.sv
// Shared types for the trace instruction filter.
package trdb_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ACTIVE   = 2'd1,
    OFF_REQ  = 2'd2
  } filter_state_e;

endpackage

// File: rtl/trdb_range_cmp.sv
// Combinational qualifier: address window (inclusive, unsigned) plus privilege mask.
module trdb_range_cmp #(
  parameter int XLEN = 32
) (
  input  logic            filter_en_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic [XLEN-1:0] addr_lower_i,
  input  logic [XLEN-1:0] addr_upper_i,
  input  logic [1:0]      priv_lvl_i,
  input  logic [3:0]      priv_mask_i,
  output logic            match_o
);

  logic in_range;

  // lower > upper yields an empty window with no special casing.
  assign in_range = (iaddr_i >= addr_lower_i) && (iaddr_i <= addr_upper_i);
  assign match_o  = !filter_en_i || (in_range && priv_mask_i[priv_lvl_i]);

endmodule

// File: rtl/trdb_filter.sv
// Qualifies retired instructions, forwards matches through a register slice and
// requests trace-off after HOLDOFF consecutive non-matching retirements.
module trdb_filter
  import trdb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int HOLDOFF = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            trace_enable_i,
  input  logic            inst_valid_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic [1:0]      priv_lvl_i,
  input  logic            filter_en_i,
  input  logic [XLEN-1:0] addr_lower_i,
  input  logic [XLEN-1:0] addr_upper_i,
  input  logic [3:0]      priv_mask_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] iaddr_o,
  output logic            trace_req_off_o,
  output logic [1:0]      state_o
);

  localparam int                CNT_W    = $clog2(HOLDOFF + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLDOFF - 1);

  filter_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] iaddr_q, iaddr_d;
  logic            match, hit, miss;

  trdb_range_cmp #(.XLEN(XLEN)) u_range_cmp (
    .filter_en_i  (filter_en_i),
    .iaddr_i      (iaddr_i),
    .addr_lower_i (addr_lower_i),
    .addr_upper_i (addr_upper_i),
    .priv_lvl_i   (priv_lvl_i),
    .priv_mask_i  (priv_mask_i),
    .match_o      (match)
  );

  assign hit  = inst_valid_i && match;
  assign miss = inst_valid_i && !match;

  // NOTE: every register, including the address slice, has a reset value so a
  // reset in OFF_REQ drops the request and all outputs immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DISABLED;
    end else begin
      // NOTE: non-blocking so all flops sample pre-edge values together.
      state_q <= state_d;
    end
  end

  // A falling enable takes priority over the HOLDOFF-th mismatch.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      DISABLED: if (trace_enable_i) state_d = ACTIVE;
      ACTIVE: begin
        if (!trace_enable_i)                  state_d = DISABLED;
        else if (miss && (cnt_q == CNT_LAST)) state_d = OFF_REQ;
      end
      OFF_REQ:  if (!trace_enable_i) state_d = DISABLED;
      default:  state_d = DISABLED;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == DISABLED) || !trace_enable_i) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = '0;
    end else if (miss && (state_q == ACTIVE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    valid_d = inst_valid_i && trace_enable_i && match && (state_q != OFF_REQ);
    iaddr_d = inst_valid_i ? iaddr_i : iaddr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      iaddr_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      iaddr_q <= iaddr_d;
    end
  end

  always_comb begin
    inst_valid_o    = valid_q;
    iaddr_o         = iaddr_q;
    trace_req_off_o = (state_q == OFF_REQ);
    state_o         = state_q;
  end

endmodule

// File: doc/trdb_filter.md
# trdb_filter

Instruction filter stage directly upstream of the trace control registers. It qualifies each retired instruction against a configurable address range and privilege mask, and forwards only qualifying instructions to the packet emitter through a one-cycle register slice. After a programmable number of consecutive non-qualifying retirements, it raises the level request `trace_req_off_o`, which the control register block edge-detects to switch tracing off.

## Interface
- `XLEN`, 32: instruction address width.
- `HOLDOFF`, 4: consecutive non-matching valid retirements before an off request; legal range 1..255.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Asynchronous, active-low.
- `trace_enable_i` in 1: tracing enabled, driven by the control register block.
- `inst_valid_i` in 1: one instruction retired this cycle.
- `iaddr_i` in XLEN: address of the retired instruction.
- `priv_lvl_i` in 2: privilege of the retired instruction (0=U, 1=S, 3=M).
- `filter_en_i` in 1: 0 means every instruction matches.
- `addr_lower_i` in XLEN: inclusive lower bound of the range.
- `addr_upper_i` in XLEN: inclusive upper bound of the range.
- `priv_mask_i` in 4: bit p set means privilege p is traced.
- `inst_valid_o` out 1: qualified retirement, registered.
- `iaddr_o` out XLEN: registered copy of `iaddr_i`.
- `trace_req_off_o` out 1: level request to stop tracing.
- `state_o` out 2: current FSM state, for debug.

## Operation
- Match rule:
  - match = `!filter_en_i` OR (`addr_lower_i` <= `iaddr_i` <= `addr_upper_i`, unsigned, AND `priv_mask_i[priv_lvl_i]`).
  - If lower > upper, the range is empty, so match = 0 whenever the filter is enabled.
- Qualification: `inst_valid_o` takes `inst_valid_i & trace_enable_i & match & (state != OFF_REQ)` on the next cycle.
- `iaddr_o` loads on every `inst_valid_i` regardless of match; it holds otherwise.
- Mismatch counter: CNT_W = $clog2(HOLDOFF+1) bits.
  - Increments on each valid non-matching retirement while in ACTIVE.
  - Clears on a valid matching retirement.
  - Saturates at HOLDOFF.
  - Cycles without `inst_valid_i` leave it unchanged.
- FSM states: DISABLED=0, ACTIVE=1, OFF_REQ=2.
  - DISABLED -> ACTIVE when `trace_enable_i`=1. The counter clears on entry.
  - ACTIVE -> OFF_REQ on the valid mismatch that brings the counter to HOLDOFF.
  - ACTIVE -> DISABLED when `trace_enable_i`=0. The counter clears.
  - OFF_REQ -> DISABLED when `trace_enable_i`=0.
- `trace_req_off_o` = 1 exactly while state is OFF_REQ.
- Simultaneous `trace_enable_i` fall and the HOLDOFF-th mismatch: the enable fall wins and the next state is DISABLED, with no request.
- Changing `filter_en_i` or the bounds mid-trace takes effect on the next retirement. The counter is not cleared.
- Reset mid-operation: all state returns to reset values immediately. Any pending request is dropped.

## Timing
- Reset values:
  - `inst_valid_o`=0, `iaddr_o`=0, `trace_req_off_o`=0, `state_o`=DISABLED.
  - Counter=0.
- All outputs are registered. There is no combinational input-to-output path.
- Latency: `inst_valid_i` at cycle N gives `inst_valid_o` at N+1.
- `trace_req_off_o` rises in the cycle after the HOLDOFF-th mismatch is sampled.
  - It stays high until the cycle after `trace_enable_i` is sampled low.
- `trace_enable_i` is sampled on the same edge as `inst_valid_i`. A retirement in the cycle where enable first goes high is already qualified.

## Structure
- `trdb_pkg` holds `filter_state_e` (2-bit enum DISABLED/ACTIVE/OFF_REQ).
- One combinational sub-module, `trdb_range_cmp`, computes the match bit from the address, bounds, privilege, mask and enable.
- The FSM, counter and output slice live in `trdb_filter`.

## Test plan
- Reset: hold `rst_ni`=0 with active stimulus -> all outputs 0 and state DISABLED. Release -> first enabled valid instruction appears one cycle later.
- Range qualification: range 0x1000..0x1FFF, enable=1, retire 0x0FFC, 0x1000, 0x1FFC, 0x2000 -> `inst_valid_o` = 0,1,1,0 one cycle delayed; `iaddr_o` tracks all four.
- Holdoff: HOLDOFF=4, retire 3 out-of-range, 1 in-range, then 4 out-of-range -> `trace_req_off_o` rises one cycle after the 8th retirement. Drop `trace_enable_i` -> request clears next cycle and state is DISABLED.
- Privilege mask: mask=4'b1000, address in range, priv 0 then 3 -> only the M-mode retirement is forwarded and the counter is 1 after the U-mode one.
- Corner cases:
  - Empty range (lower=0x2000 > upper=0x1000) with filter enabled -> nothing forwarded and the request fires after HOLDOFF retirements.
  - `filter_en_i`=0 -> everything is forwarded and no request occurs.
- Simultaneous events:
  - Enable fall together with the HOLDOFF-th mismatch -> state DISABLED and `trace_req_off_o` stays 0.
  - Async reset asserted while in OFF_REQ -> request drops immediately.
